// File: rtl/keypad_digit_collector.sv
// Debounces the keypad encoder code, turns each clean 0->k press into a digit,
// and collects NUM_DIGITS digits into an entry word offered over valid/ready.
module keypad_digit_collector #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int NUM_DIGITS      = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [3:0]                         key_code,
    input  logic                               clear,
    input  logic                               out_ready,
    output logic [4*NUM_DIGITS-1:0]            digits,
    output logic [$clog2(NUM_DIGITS+1)-1:0]    digit_count,
    output logic                               out_valid,
    output logic                               key_pulse,
    output logic                               key_held,
    output logic                               overrun
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int CW    = $clog2(NUM_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_THR  = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CW-1:0]    FULL_CNT = CW'(NUM_DIGITS);

    // out_valid is the FULL state; handshake: word transfers on out_valid & out_ready.
    typedef enum logic {ST_ENTRY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cand_q, cand_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [3:0]              stable_q, stable_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    pulse_q, pulse_d;
    logic                    overrun_q, overrun_d;
    logic                    held_q, held_d;
    logic [3:0]              key_s;
    logic                    press;
    logic [4*NUM_DIGITS+3:0] shifted;

    assign key_s = (key_code > 4'd9) ? 4'd0 : key_code;

    // stable takes cand on the same edge that completes the DEBOUNCE_CYCLES-long run.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (key_s != cand_q) begin
            cand_d = key_s;
            cnt_d  = '0;
        end else begin
            if (cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
            if ((cnt_q >= CNT_THR) && (cand_q != stable_q)) stable_d = cand_q;
        end
    end

    assign press   = (stable_q == 4'd0) && (stable_d != 4'd0);
    assign shifted = {digits_q, stable_d};
    assign held_d  = (stable_d != 4'd0);

    always_comb begin
        state_d   = state_q;
        digits_d  = digits_q;
        count_d   = count_q;
        pulse_d   = 1'b0;
        overrun_d = 1'b0;
        if (clear) begin
            state_d  = ST_ENTRY;
            digits_d = '0;
            count_d  = '0;
        end else begin
            case (state_q)
                ST_ENTRY: begin
                    if (press) begin
                        digits_d = shifted[4*NUM_DIGITS-1:0];
                        count_d  = count_q + 1'b1;
                        pulse_d  = 1'b1;
                        if (count_q + 1'b1 == FULL_CNT) state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    overrun_d = press;
                    if (out_ready) begin
                        state_d  = ST_ENTRY;
                        digits_d = '0;
                        count_d  = '0;
                    end
                end
                default: state_d = ST_ENTRY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ENTRY;
            cand_q    <= '0;
            cnt_q     <= '0;
            stable_q  <= '0;
            digits_q  <= '0;
            count_q   <= '0;
            pulse_q   <= 1'b0;
            overrun_q <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            digits_q  <= digits_d;
            count_q   <= count_d;
            pulse_q   <= pulse_d;
            overrun_q <= overrun_d;
            held_q    <= held_d;
        end
    end

    assign digits      = digits_q;
    assign digit_count = count_q;
    assign out_valid   = (state_q == ST_FULL);
    assign key_pulse   = pulse_q;
    assign key_held    = held_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_keypad_digit_collector.sv
// Bench for keypad_digit_collector: directed scenarios plus randomized key
// sequences, every cycle compared against a run-length/queue reference model.
module tb_keypad_digit_collector;

    localparam int DC = 4;
    localparam int ND = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  key_code;
    logic        clear;
    logic        out_ready;
    logic [15:0] digits;
    logic [2:0]  digit_count;
    logic        out_valid;
    logic        key_pulse;
    logic        key_held;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    // Reference model state
    int         m_run_val;
    int         m_run_len;
    int         m_stable;
    logic [3:0] exp_q[$];
    bit         m_valid;
    bit         m_pulse;
    bit         m_over;
    bit         m_held;

    keypad_digit_collector #(.DEBOUNCE_CYCLES(DC), .NUM_DIGITS(ND)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_code    (key_code),
        .clear       (clear),
        .out_ready   (out_ready),
        .digits      (digits),
        .digit_count (digit_count),
        .out_valid   (out_valid),
        .key_pulse   (key_pulse),
        .key_held    (key_held),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_word();
        logic [15:0] w;
        w = '0;
        foreach (exp_q[i]) w = (w << 4) | 16'(exp_q[i]);
        return w;
    endfunction

    task automatic model_reset();
        m_run_val = 0;
        m_run_len = 1;
        m_stable  = 0;
        exp_q.delete();
        m_valid = 0;
        m_pulse = 0;
        m_over  = 0;
        m_held  = 0;
    endtask

    task automatic model_step(input int k, input bit c, input bit r);
        int s;
        int prev;
        bit press;
        s    = (k > 9) ? 0 : k;
        prev = m_stable;
        if (s == m_run_val) begin
            if (m_run_len < DC) m_run_len++;
        end else begin
            m_run_val = s;
            m_run_len = 1;
        end
        if (m_run_len >= DC) m_stable = m_run_val;
        press   = (prev == 0) && (m_stable != 0);
        m_pulse = 0;
        m_over  = 0;
        if (c) begin
            exp_q.delete();
            m_valid = 0;
        end else if (!m_valid) begin
            if (press) begin
                exp_q.push_back(4'(m_stable));
                m_pulse = 1;
                if (exp_q.size() == ND) m_valid = 1;
            end
        end else begin
            if (press) m_over = 1;
            if (r) begin
                exp_q.delete();
                m_valid = 0;
            end
        end
        m_held = (m_stable != 0);
    endtask

    task automatic compare_model();
        chk("digits",      32'(digits),      32'(model_word()));
        chk("digit_count", 32'(digit_count), 32'(exp_q.size()));
        chk("out_valid",   32'(out_valid),   32'(m_valid));
        chk("key_pulse",   32'(key_pulse),   32'(m_pulse));
        chk("key_held",    32'(key_held),    32'(m_held));
        chk("overrun",     32'(overrun),     32'(m_over));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_digits"},  32'(digits),      32'h0);
        chk({tag, "_count"},   32'(digit_count), 32'h0);
        chk({tag, "_valid"},   32'(out_valid),   32'h0);
        chk({tag, "_pulse"},   32'(key_pulse),   32'h0);
        chk({tag, "_held"},    32'(key_held),    32'h0);
        chk({tag, "_overrun"}, 32'(overrun),     32'h0);
    endtask

    task automatic tick(input logic [3:0] k, input logic c, input logic r);
        key_code  = k;
        clear     = c;
        out_ready = r;
        @(posedge clk);
        model_step(int'(k), c, r);
        #1;
        if (key_pulse) pulse_cnt++;
        compare_model();
    endtask

    task automatic press_key(input logic [3:0] k);
        repeat (DC) tick(k, 1'b0, 1'b0);
        repeat (DC) tick(4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        key_code  = 4'd0;
        clear     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Debounced press of 3, then release
        pulse_cnt = 0;
        repeat (DC - 1) tick(4'd3, 1'b0, 1'b0);
        chk("press3_early_pulse", 32'(key_pulse), 32'h0);
        tick(4'd3, 1'b0, 1'b0);
        chk("press3_pulse",  32'(key_pulse),   32'h1);
        chk("press3_digits", 32'(digits),      32'h0003);
        chk("press3_count",  32'(digit_count), 32'h1);
        chk("press3_held",   32'(key_held),    32'h1);
        repeat (DC - 1) tick(4'd0, 1'b0, 1'b0);
        chk("release_held_still", 32'(key_held), 32'h1);
        tick(4'd0, 1'b0, 1'b0);
        chk("release_held", 32'(key_held), 32'h0);
        chk("press3_once",  32'(pulse_cnt), 32'h1);

        // Glitch of 7 shorter than the debounce window
        pulse_cnt = 0;
        repeat (DC - 1) tick(4'd7, 1'b0, 1'b0);
        repeat (DC) tick(4'd0, 1'b0, 1'b0);
        chk("glitch_pulses", 32'(pulse_cnt),   32'h0);
        chk("glitch_digits", 32'(digits),      32'h0003);
        chk("glitch_held",   32'(key_held),    32'h0);

        // Full entry 1,2,3,4
        tick(4'd0, 1'b1, 1'b0);
        chk("clear_count", 32'(digit_count), 32'h0);
        press_key(4'd1);
        press_key(4'd2);
        press_key(4'd3);
        repeat (DC - 1) tick(4'd4, 1'b0, 1'b0);
        chk("full_not_yet", 32'(out_valid), 32'h0);
        tick(4'd4, 1'b0, 1'b0);
        chk("full_pulse",  32'(key_pulse),   32'h1);
        chk("full_valid",  32'(out_valid),   32'h1);
        chk("full_digits", 32'(digits),      32'h1234);
        chk("full_count",  32'(digit_count), 32'h4);
        repeat (DC + 2) tick(4'd0, 1'b0, 1'b0);
        chk("full_hold_valid",  32'(out_valid), 32'h1);
        chk("full_hold_digits", 32'(digits),    32'h1234);

        // Overrun while full, then handshake
        repeat (DC - 1) tick(4'd9, 1'b0, 1'b0);
        tick(4'd9, 1'b0, 1'b0);
        chk("ovr_pulse",  32'(overrun),   32'h1);
        chk("ovr_nokey",  32'(key_pulse), 32'h0);
        chk("ovr_digits", 32'(digits),    32'h1234);
        repeat (DC) tick(4'd0, 1'b0, 1'b0);
        chk("ovr_valid_held", 32'(out_valid), 32'h1);
        tick(4'd0, 1'b0, 1'b1);
        chk("hs_valid",  32'(out_valid),   32'h0);
        chk("hs_digits", 32'(digits),      32'h0);
        chk("hs_count",  32'(digit_count), 32'h0);

        // Key slide 5 -> 6 without release, then clear
        pulse_cnt = 0;
        repeat (8) tick(4'd5, 1'b0, 1'b0);
        repeat (8) tick(4'd6, 1'b0, 1'b0);
        repeat (DC) tick(4'd0, 1'b0, 1'b0);
        chk("slide_pulses", 32'(pulse_cnt),   32'h1);
        chk("slide_digits", 32'(digits),      32'h0005);
        chk("slide_count",  32'(digit_count), 32'h1);
        tick(4'd0, 1'b1, 1'b0);
        chk("slide_clear_count", 32'(digit_count), 32'h0);
        chk("slide_clear_valid", 32'(out_valid),   32'h0);

        // Reset mid-entry with key 8 held across release
        press_key(4'd1);
        press_key(4'd2);
        chk("pre_rst_count", 32'(digit_count), 32'h2);
        key_code = 4'd8;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all_zero("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst_held");
        rst = 1'b0;
        repeat (DC - 1) tick(4'd8, 1'b0, 1'b0);
        chk("rst8_early_pulse", 32'(key_pulse),   32'h0);
        chk("rst8_early_count", 32'(digit_count), 32'h0);
        tick(4'd8, 1'b0, 1'b0);
        chk("rst8_pulse",  32'(key_pulse),   32'h1);
        chk("rst8_digits", 32'(digits),      32'h0008);
        chk("rst8_count",  32'(digit_count), 32'h1);
        repeat (DC) tick(4'd0, 1'b0, 1'b0);

        // Randomized key runs against the reference model
        for (int n = 0; n < 600; n++) begin
            logic [3:0] k;
            int         len;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: k = 4'd0;
                4:          k = 4'($urandom_range(10, 15));
                default:    k = 4'($urandom_range(1, 9));
            endcase
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                tick(k, ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
